// File: rtl/scan_cfg_loader_pkg.sv
// rtl/scan_cfg_loader_pkg.sv - FSM state encoding and default sizes for the scan config loader
package scan_cfg_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam int DEF_WORD_W    = 8;
  localparam int DEF_CHAIN_LEN = 64;

endpackage

// File: rtl/scan_cfg_loader_if.sv
// rtl/scan_cfg_loader_if.sv - host word stream, scan chain pins and status of the scan config loader
interface scan_cfg_loader_if
  import scan_cfg_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) ();

  logic              start;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              scan_in;
  logic              scan_en;
  logic              scan_out_fb;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  modport slave (
    input  start, in_data, in_valid, scan_out_fb,
    output in_ready, scan_in, scan_en, busy, done, rb_data, rb_valid
  );

  modport master (
    output start, in_data, in_valid, scan_out_fb,
    input  in_ready, scan_in, scan_en, busy, done, rb_data, rb_valid
  );

endinterface

// File: rtl/scan_word_ser.sv
// rtl/scan_word_ser.sv - one-word PISO, MSB first, with bit counter and last-bit flag
module scan_word_ser
  import scan_cfg_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              scan_clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_data,
  output logic              o_bit,
  output logic              o_last_bit
);

  localparam int BIT_W = $clog2(WORD_W);

  logic [WORD_W-1:0] r_sreg;
  logic [BIT_W-1:0]  r_bit;
  logic              w_last;

  assign w_last     = (r_bit == BIT_W'(WORD_W - 1));
  assign o_bit      = r_sreg[WORD_W-1];
  assign o_last_bit = w_last;

  always_ff @(posedge scan_clk or posedge reset) begin
    if (reset) begin
      r_sreg <= '0;
      r_bit  <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
      r_bit  <= '0;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
      r_bit  <= w_last ? '0 : r_bit + BIT_W'(1);
    end
  end

endmodule

// File: rtl/scan_cfg_loader.sv
// rtl/scan_cfg_loader.sv - serialises config words onto the scan chain, CHAIN_LEN shifts per load
// Optional readback capture of scan_out_fb is enabled by SCAN_CFG_READBACK_EN.
module scan_cfg_loader
  import scan_cfg_loader_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
  input logic               scan_clk,
  input logic               reset,
  scan_cfg_loader_if.slave  bus
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_total;
  logic             w_load;
  logic             w_shift;
  logic             w_clr;
  logic             w_ser_bit;
  logic             w_last_bit;
  logic             w_total_last;

  scan_word_ser #(.WORD_W(WORD_W)) u_ser (
    .scan_clk   (scan_clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (bus.in_data),
    .o_bit      (w_ser_bit),
    .o_last_bit (w_last_bit)
  );

  assign w_total_last = (r_total == CNT_W'(CHAIN_LEN - 1));

  always_ff @(posedge scan_clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge scan_clk or posedge reset) begin
    if (reset)        r_total <= '0;
    else if (w_clr)   r_total <= '0;
    else if (w_shift) r_total <= r_total + CNT_W'(1);
  end

  // The chain-length limit wins over word boundaries, dropping unused low bits.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_clr  = 1'b1;
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid) begin
          w_load = 1'b1;
          w_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (w_total_last)    w_next = ST_FIN;
        else if (w_last_bit) w_next = ST_LOAD;
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.in_ready = (r_state == ST_LOAD);
  assign bus.scan_en  = (r_state == ST_SHIFT);
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = (r_state == ST_FIN);
  assign bus.scan_in  = w_ser_bit;

`ifdef SCAN_CFG_READBACK_EN
  localparam int RB_W = $clog2(WORD_W);

  logic [WORD_W-1:0] r_rb_sh;
  logic [RB_W-1:0]   r_rb_cnt;
  logic [WORD_W-1:0] r_rb_data;
  logic              r_rb_valid;
  logic [WORD_W-1:0] w_rb_word;
  logic [RB_W-1:0]   w_rb_pad;

  assign w_rb_word = {r_rb_sh[WORD_W-2:0], bus.scan_out_fb};
  assign w_rb_pad  = RB_W'(WORD_W - 1) - r_rb_cnt;

  always_ff @(posedge scan_clk or posedge reset) begin
    if (reset) begin
      r_rb_sh    <= '0;
      r_rb_cnt   <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (w_clr) begin
        r_rb_cnt <= '0;
      end else if (w_shift) begin
        r_rb_sh <= w_rb_word;
        if (r_rb_cnt == RB_W'(WORD_W - 1)) begin
          r_rb_data  <= w_rb_word;
          r_rb_valid <= 1'b1;
          r_rb_cnt   <= '0;
        end else if (w_total_last) begin
          r_rb_data  <= w_rb_word << w_rb_pad;
          r_rb_valid <= 1'b1;
          r_rb_cnt   <= '0;
        end else begin
          r_rb_cnt <= r_rb_cnt + RB_W'(1);
        end
      end
    end
  end

  assign bus.rb_data  = r_rb_data;
  assign bus.rb_valid = r_rb_valid;
`else
  logic w_unused_fb;
  assign w_unused_fb  = bus.scan_out_fb;
  assign bus.rb_data  = '0;
  assign bus.rb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_scan_cfg_loader.sv
// tb/tb_scan_cfg_loader.sv - directed bench: loader driving 16-bit and 12-bit modelled scan chains
module tb_scan_cfg_loader;

  logic clk;
  logic rst16;
  logic rst12;
  logic cnt_clr;
  logic preset16_en;
  logic [15:0] preset16_val;
  logic preset12_en;

  logic [15:0] chain16;
  logic [11:0] chain12;
  int en16, done16, en12, done12, rb_n;
  logic [7:0] rb_log [4];

  int checks;
  int failures;

  scan_cfg_loader_if #(.WORD_W(8)) if16 ();
  scan_cfg_loader_if #(.WORD_W(8)) if12 ();

  scan_cfg_loader #(.WORD_W(8), .CHAIN_LEN(16)) u_dut16 (
    .scan_clk (clk),
    .reset    (rst16),
    .bus      (if16.slave)
  );

  scan_cfg_loader #(.WORD_W(8), .CHAIN_LEN(12)) u_dut12 (
    .scan_clk (clk),
    .reset    (rst12),
    .bus      (if12.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign if16.scan_out_fb = chain16[15];
  assign if12.scan_out_fb = chain12[11];

  // Behavioural scan chains: first bit shifted in ends up at the MSB.
  always @(posedge clk) begin
    if (preset16_en)       chain16 <= preset16_val;
    else if (if16.scan_en) chain16 <= {chain16[14:0], if16.scan_in};
    if (preset12_en)       chain12 <= 12'h000;
    else if (if12.scan_en) chain12 <= {chain12[10:0], if12.scan_in};
  end

  always @(posedge clk) begin
    if (cnt_clr) begin
      en16 <= 0; done16 <= 0; en12 <= 0; done12 <= 0; rb_n <= 0;
    end else begin
      if (if16.scan_en) en16 <= en16 + 1;
      if (if16.done)    done16 <= done16 + 1;
      if (if12.scan_en) en12 <= en12 + 1;
      if (if12.done)    done12 <= done12 + 1;
      if (if16.rb_valid) begin
        if (rb_n < 4) rb_log[rb_n] <= if16.rb_data;
        rb_n <= rb_n + 1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic start16();
    if16.start = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
  endtask

  task automatic start12();
    if12.start = 1'b1;
    @(negedge clk);
    if12.start = 1'b0;
  endtask

  task automatic feed16(input logic [7:0] w);
    int n;
    n = 0;
    if16.in_data  = w;
    if16.in_valid = 1'b1;
    while (!if16.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("feed16_ready_seen", 32'(n < 50), 32'd1);
    @(negedge clk);
    if16.in_valid = 1'b0;
  endtask

  task automatic feed12(input logic [7:0] w);
    int n;
    n = 0;
    if12.in_data  = w;
    if12.in_valid = 1'b1;
    while (!if12.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("feed12_ready_seen", 32'(n < 50), 32'd1);
    @(negedge clk);
    if12.in_valid = 1'b0;
  endtask

  task automatic wait_done16(input bit pulse_start);
    int n;
    n = 0;
    while (!if16.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done16_seen", 32'(n < 60), 32'd1);
    if (pulse_start) begin
      if16.start = 1'b1;
      @(negedge clk);
      if16.start = 1'b0;
      chk("t6_busy_after_fin", 32'(if16.busy), 32'd0);
      @(negedge clk);
      chk("t6_fin_start_ignored_ready", 32'(if16.in_ready), 32'd0);
      chk("t6_fin_start_ignored_busy", 32'(if16.busy), 32'd0);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst16 = 1'b1;
    rst12 = 1'b1;
    cnt_clr = 1'b1;
    preset16_en = 1'b1;
    preset16_val = 16'h0000;
    preset12_en = 1'b1;
    if16.start = 1'b0; if16.in_valid = 1'b0; if16.in_data = 8'h00;
    if12.start = 1'b0; if12.in_valid = 1'b0; if12.in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst16 = 1'b0;
    rst12 = 1'b0;
    cnt_clr = 1'b0;
    preset16_en = 1'b0;
    preset12_en = 1'b0;
    @(negedge clk);

    chk("rst_scan_en", 32'(if16.scan_en), 32'd0);
    chk("rst_scan_in", 32'(if16.scan_in), 32'd0);
    chk("rst_in_ready", 32'(if16.in_ready), 32'd0);
    chk("rst_busy", 32'(if16.busy), 32'd0);
    chk("rst_done", 32'(if16.done), 32'd0);
    chk("rst_rb_valid", 32'(if16.rb_valid), 32'd0);
    chk("rst_rb_data", 32'(if16.rb_data), 32'd0);

    // 1: back-to-back words
    if16.in_valid = 1'b1;
    if16.in_data = 8'h77;
    @(negedge clk);
    chk("t1_idle_ignores_valid", 32'(if16.busy), 32'd0);
    if16.in_valid = 1'b0;
    start16();
    chk("t1_load_ready", 32'(if16.in_ready), 32'd1);
    chk("t1_load_busy", 32'(if16.busy), 32'd1);
    chk("t1_load_scan_en", 32'(if16.scan_en), 32'd0);
    feed16(8'hA5);
    chk("t1_first_bit", 32'(if16.scan_in), 32'd1);
    feed16(8'h3C);
    wait_done16(1'b0);
    chk("t1_chain", 32'(chain16), 32'h0000A53C);
    chk("t1_scan_en_cycles", 32'(en16), 32'd16);
    chk("t1_done_pulses", 32'(done16), 32'd1);
    chk("t1_busy_end", 32'(if16.busy), 32'd0);
    `ifndef SCAN_CFG_READBACK_EN
    chk("t1_no_rb_pulses", 32'(rb_n), 32'd0);
    `endif

    // 2: gap between words
    clear_counts();
    start16();
    feed16(8'hA5);
    begin
      int n;
      n = 0;
      while (!if16.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t2_reach_load", 32'(n < 50), 32'd1);
    end
    repeat (5) @(negedge clk);
    chk("t2_gap_scan_en_cycles", 32'(en16), 32'd8);
    chk("t2_gap_chain", 32'(chain16), 32'h00003CA5);
    chk("t2_gap_ready", 32'(if16.in_ready), 32'd1);
    feed16(8'h3C);
    wait_done16(1'b0);
    chk("t2_chain", 32'(chain16), 32'h0000A53C);
    chk("t2_scan_en_cycles", 32'(en16), 32'd16);
    chk("t2_done_pulses", 32'(done16), 32'd1);

    // 3: 12-bit chain drops the low nibble of the second word
    clear_counts();
    start12();
    feed12(8'hAB);
    feed12(8'hCD);
    begin
      int n;
      n = 0;
      while (!if12.done && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("t3_done_seen", 32'(n < 60), 32'd1);
    end
    @(negedge clk);
    chk("t3_chain", 32'(chain12), 32'h00000ABC);
    chk("t3_scan_en_cycles", 32'(en12), 32'd12);
    chk("t3_done_pulses", 32'(done12), 32'd1);
    chk("t3_idle_ready", 32'(if12.in_ready), 32'd0);

    // 4: readback of preset chain contents
    preset16_val = 16'h1234;
    preset16_en = 1'b1;
    @(negedge clk);
    preset16_en = 1'b0;
    clear_counts();
    start16();
    feed16(8'hA5);
    feed16(8'h3C);
    wait_done16(1'b0);
    @(negedge clk);
    chk("t4_chain", 32'(chain16), 32'h0000A53C);
    `ifdef SCAN_CFG_READBACK_EN
    chk("t4_rb_pulses", 32'(rb_n), 32'd2);
    chk("t4_rb_word0", 32'(rb_log[0]), 32'h12);
    chk("t4_rb_word1", 32'(rb_log[1]), 32'h34);
    `else
    chk("t4_rb_pulses", 32'(rb_n), 32'd0);
    chk("t4_rb_data", 32'(if16.rb_data), 32'd0);
    `endif

    // 5: reset mid-load then full reload
    clear_counts();
    start16();
    feed16(8'hA5);
    repeat (5) @(negedge clk);
    chk("t5_bits_before_reset", 32'(en16), 32'd5);
    rst16 = 1'b1;
    #1;
    chk("t5_rst_scan_en", 32'(if16.scan_en), 32'd0);
    chk("t5_rst_busy", 32'(if16.busy), 32'd0);
    chk("t5_rst_in_ready", 32'(if16.in_ready), 32'd0);
    @(negedge clk);
    rst16 = 1'b0;
    clear_counts();
    start16();
    feed16(8'hFF);
    feed16(8'hFF);
    wait_done16(1'b0);
    chk("t5_chain", 32'(chain16), 32'h0000FFFF);
    chk("t5_scan_en_cycles", 32'(en16), 32'd16);

    // 6: start pulses mid-shift and during FIN are ignored
    clear_counts();
    start16();
    feed16(8'h5A);
    if16.start = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
    chk("t6_mid_shift_scan_en", 32'(if16.scan_en), 32'd1);
    feed16(8'hC3);
    wait_done16(1'b1);
    chk("t6_chain", 32'(chain16), 32'h00005AC3);
    chk("t6_scan_en_cycles", 32'(en16), 32'd16);
    chk("t6_done_pulses", 32'(done16), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
